// File: rtl/bomb_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : bomb_sequencer
//  Description : Two-player scheduler for the single bomb slot. Arbitrates
//                drop requests, drives make/explode towards the bomb
//                datapath and times the fuse, flame and cooldown phases.
//  Revision    : 1.0 - initial release
// ============================================================================
module bomb_sequencer #(
    parameter int FUSE_FRAMES     = 180,
    parameter int FLAME_FRAMES    = 30,
    parameter int COOLDOWN_FRAMES = 10,
    parameter int ARM_TIMEOUT     = 4,
    parameter int CNT_W           = 8
) (
    input  logic             frame_clk,
    input  logic             Reset,
    input  logic             req_p1,
    input  logic             req_p2,
    input  logic             bomb_check,
    output logic             make,
    output logic             explode,
    output logic             owner,
    output logic             grant,
    output logic             abort,
    output logic             flame_on,
    output logic [CNT_W-1:0] fuse_left,
    output logic             busy
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ARM     = 3'd1,
        S_FUSE    = 3'd2,
        S_EXPLODE = 3'd3,
        S_FLAME   = 3'd4,
        S_COOL    = 3'd5
    } state_t;

    localparam logic [CNT_W-1:0] C_FUSE_LOAD  = CNT_W'(FUSE_FRAMES - 1);
    localparam logic [CNT_W-1:0] C_FLAME_LAST = CNT_W'(FLAME_FRAMES - 1);
    localparam logic [CNT_W-1:0] C_COOL_LAST  = CNT_W'(COOLDOWN_FRAMES - 1);
    localparam logic [CNT_W-1:0] C_ARM_LAST   = CNT_W'(ARM_TIMEOUT - 1);

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_last_win;

    state_t           w_state_next;
    logic [CNT_W-1:0] w_cnt_next;
    logic             w_last_win_next;
    logic             w_winner;
    logic             w_make_next;
    logic             w_explode_next;
    logic             w_owner_next;
    logic             w_grant_next;
    logic             w_abort_next;
    logic             w_flame_next;
    logic [CNT_W-1:0] w_fuse_next;
    logic             w_busy_next;

    // State, phase counter and every output are registered here
    always_ff @(posedge frame_clk) begin
        if (Reset) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_last_win <= 1'b1;      // P2 "won last", so P1 wins the first tie
            make       <= 1'b0;
            explode    <= 1'b0;
            owner      <= 1'b0;
            grant      <= 1'b0;
            abort      <= 1'b0;
            flame_on   <= 1'b0;
            fuse_left  <= '0;
            busy       <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_cnt      <= w_cnt_next;
            r_last_win <= w_last_win_next;
            make       <= w_make_next;
            explode    <= w_explode_next;
            owner      <= w_owner_next;
            grant      <= w_grant_next;
            abort      <= w_abort_next;
            flame_on   <= w_flame_next;
            fuse_left  <= w_fuse_next;
            busy       <= w_busy_next;
        end
    end

    // Next-state and next-output decode; strobes hold unless a transition moves them
    always_comb begin
        w_state_next    = r_state;
        w_cnt_next      = r_cnt;
        w_last_win_next = r_last_win;
        w_make_next     = make;
        w_explode_next  = explode;
        w_owner_next    = owner;
        w_grant_next    = 1'b0;
        w_abort_next    = 1'b0;
        w_flame_next    = flame_on;
        w_fuse_next     = fuse_left;
        // Round-robin on a tie, otherwise whoever is asking
        w_winner        = (req_p1 && req_p2) ? ~r_last_win : req_p2;

        case (r_state)
            S_IDLE: begin
                if (req_p1 || req_p2) begin
                    w_owner_next    = w_winner;
                    w_last_win_next = w_winner;
                    w_grant_next    = 1'b1;
                    w_make_next     = 1'b1;
                    w_cnt_next      = '0;
                    w_state_next    = S_ARM;
                end
            end
            S_ARM: begin
                if (bomb_check) begin
                    w_make_next  = 1'b0;
                    w_fuse_next  = C_FUSE_LOAD;
                    w_cnt_next   = '0;
                    w_state_next = S_FUSE;
                end else if (r_cnt == C_ARM_LAST) begin
                    // Datapath never confirmed the bomb: give the slot back
                    w_make_next  = 1'b0;
                    w_abort_next = 1'b1;
                    w_cnt_next   = '0;
                    w_state_next = S_IDLE;
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                end
            end
            S_FUSE: begin
                if (!bomb_check) begin
                    // Bomb cleared externally: skip the detonation request
                    w_fuse_next  = '0;
                    w_flame_next = 1'b1;
                    w_cnt_next   = '0;
                    w_state_next = S_FLAME;
                end else if (fuse_left == '0) begin
                    w_explode_next = 1'b1;
                    w_state_next   = S_EXPLODE;
                end else begin
                    w_fuse_next = fuse_left - 1'b1;
                end
            end
            S_EXPLODE: begin
                if (!bomb_check) begin
                    w_explode_next = 1'b0;
                    w_flame_next   = 1'b1;
                    w_cnt_next     = '0;
                    w_state_next   = S_FLAME;
                end
            end
            S_FLAME: begin
                if (r_cnt == C_FLAME_LAST) begin
                    w_flame_next = 1'b0;
                    w_cnt_next   = '0;
                    w_state_next = S_COOL;
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                end
            end
            S_COOL: begin
                if (r_cnt == C_COOL_LAST) begin
                    w_cnt_next   = '0;
                    w_state_next = S_IDLE;
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                end
            end
            default: begin
                w_state_next   = S_IDLE;
                w_cnt_next     = '0;
                w_make_next    = 1'b0;
                w_explode_next = 1'b0;
                w_flame_next   = 1'b0;
                w_fuse_next    = '0;
            end
        endcase

        w_busy_next = (w_state_next != S_IDLE);
    end

endmodule
`default_nettype wire

// File: tb/tb_bomb_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bomb_sequencer
//  Description : Directed self-checking bench for bomb_sequencer with a small
//                bomb datapath model (bomb appears the frame after make is
//                seen, disappears within the frame explode is asserted).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_bomb_sequencer;

    logic       frame_clk;
    logic       Reset;
    logic       req_p1;
    logic       req_p2;
    logic       bomb_check;
    logic       make;
    logic       explode;
    logic       owner;
    logic       grant;
    logic       abort;
    logic       flame_on;
    logic [7:0] fuse_left;
    logic       busy;

    // Bomb datapath model controls
    logic r_bomb;
    logic never_arm;
    logic kill;

    int n_checks;
    int n_errors;
    int n_grant;
    int n_make;
    int n_explode;
    int n_flame;
    int n_abort;

    bomb_sequencer #(
        .FUSE_FRAMES    (5),
        .FLAME_FRAMES   (3),
        .COOLDOWN_FRAMES(2),
        .ARM_TIMEOUT    (4),
        .CNT_W          (8)
    ) dut (
        .frame_clk (frame_clk),
        .Reset     (Reset),
        .req_p1    (req_p1),
        .req_p2    (req_p2),
        .bomb_check(bomb_check),
        .make      (make),
        .explode   (explode),
        .owner     (owner),
        .grant     (grant),
        .abort     (abort),
        .flame_on  (flame_on),
        .fuse_left (fuse_left),
        .busy      (busy)
    );

    always #5 frame_clk = ~frame_clk;

    // Bomb present one frame after make is seen; cleared by explode, kill or reset
    always @(posedge frame_clk) begin
        if (Reset || explode || kill)
            r_bomb <= 1'b0;
        else if (make && !never_arm)
            r_bomb <= 1'b1;
    end

    assign bomb_check = r_bomb && !explode && !kill;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge frame_clk);
        #1;
    endtask

    task automatic clear_counts();
        n_grant   = 0;
        n_make    = 0;
        n_explode = 0;
        n_flame   = 0;
        n_abort   = 0;
    endtask

    // Advance n frames, tallying strobe activity
    task automatic watch(input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            if (grant)    n_grant++;
            if (make)     n_make++;
            if (explode)  n_explode++;
            if (flame_on) n_flame++;
            if (abort)    n_abort++;
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_make"},  32'(make), 0);
        check({tag, "_expl"},  32'(explode), 0);
        check({tag, "_owner"}, 32'(owner), 0);
        check({tag, "_grant"}, 32'(grant), 0);
        check({tag, "_abort"}, 32'(abort), 0);
        check({tag, "_flame"}, 32'(flame_on), 0);
        check({tag, "_fuse"},  32'(fuse_left), 0);
        check({tag, "_busy"},  32'(busy), 0);
    endtask

    // One complete IDLE->...->IDLE pass with a one-frame request pulse
    task automatic full_seq(input logic p1, input logic p2, input logic exp_owner, input string tag);
        req_p1 = p1;
        req_p2 = p2;
        tick();
        check({tag, "_grant"}, 32'(grant), 1);
        check({tag, "_owner"}, 32'(owner), 32'(exp_owner));
        check({tag, "_make0"}, 32'(make), 1);
        check({tag, "_busy0"}, 32'(busy), 1);
        req_p1 = 1'b0;
        req_p2 = 1'b0;
        tick();
        check({tag, "_grant_off"}, 32'(grant), 0);
        check({tag, "_make1"}, 32'(make), 1);
        tick();
        check({tag, "_make_off"}, 32'(make), 0);
        check({tag, "_fuse4"}, 32'(fuse_left), 4);
        for (int i = 3; i >= 0; i--) begin
            tick();
            check({tag, "_fuse"}, 32'(fuse_left), 32'(i));
            check({tag, "_expl_fuse"}, 32'(explode), 0);
        end
        tick();
        check({tag, "_expl"}, 32'(explode), 1);
        check({tag, "_flame_pre"}, 32'(flame_on), 0);
        tick();
        check({tag, "_expl_off"}, 32'(explode), 0);
        check({tag, "_flame1"}, 32'(flame_on), 1);
        tick();
        check({tag, "_flame2"}, 32'(flame_on), 1);
        tick();
        check({tag, "_flame3"}, 32'(flame_on), 1);
        tick();
        check({tag, "_flame_off"}, 32'(flame_on), 0);
        check({tag, "_cool1"}, 32'(busy), 1);
        tick();
        check({tag, "_cool2"}, 32'(busy), 1);
        tick();
        check({tag, "_idle"}, 32'(busy), 0);
        check({tag, "_owner_hold"}, 32'(owner), 32'(exp_owner));
    endtask

    initial begin
        frame_clk = 1'b0;
        Reset     = 1'b1;
        req_p1    = 1'b0;
        req_p2    = 1'b0;
        never_arm = 1'b0;
        kill      = 1'b0;
        n_checks  = 0;
        n_errors  = 0;
        clear_counts();

        tick();
        tick();
        check_all_zero("reset");
        Reset = 1'b0;

        // Single P1 request, full timeline
        full_seq(1'b1, 1'b0, 1'b0, "t1");

        // Tie requests alternate starting with P1 after reset
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        full_seq(1'b1, 1'b1, 1'b0, "t2a");
        full_seq(1'b1, 1'b1, 1'b1, "t2b");
        full_seq(1'b1, 1'b1, 1'b0, "t2c");

        // P2 requests while busy are dropped
        req_p1 = 1'b1;
        tick();
        req_p1 = 1'b0;
        check("t3_owner0", 32'(owner), 0);
        tick();
        tick();
        req_p2 = 1'b1;
        clear_counts();
        watch(9);
        req_p2 = 1'b0;
        watch(2);
        check("t3_nogrant", 32'(n_grant), 0);
        check("t3_owner", 32'(owner), 0);
        check("t3_explode_cnt", 32'(n_explode), 1);
        check("t3_flame_cnt", 32'(n_flame), 3);
        check("t3_idle", 32'(busy), 0);
        tick();
        check("t3_idle_grant", 32'(grant), 0);

        // Bomb never confirmed: arm timeout
        never_arm = 1'b1;
        req_p1 = 1'b1;
        tick();
        req_p1 = 1'b0;
        check("t4_make0", 32'(make), 1);
        clear_counts();
        watch(3);
        check("t4_make_cnt", 32'(n_make), 3);
        check("t4_abort_early", 32'(n_abort), 0);
        tick();
        check("t4_abort", 32'(abort), 1);
        check("t4_make_off", 32'(make), 0);
        check("t4_busy", 32'(busy), 0);
        check("t4_expl", 32'(explode), 0);
        tick();
        check("t4_abort_off", 32'(abort), 0);
        never_arm = 1'b0;

        // Reset mid-fuse, then a normal P1 grant
        req_p2 = 1'b1;
        tick();
        req_p2 = 1'b0;
        check("t5_owner_p2", 32'(owner), 1);
        check("t5_grant", 32'(grant), 1);
        for (int i = 0; i < 4; i++) tick();
        check("t5_fuse2", 32'(fuse_left), 2);
        Reset = 1'b1;
        tick();
        check_all_zero("t5_rst");
        Reset = 1'b0;
        req_p1 = 1'b1;
        tick();
        req_p1 = 1'b0;
        check("t5_regrant", 32'(grant), 1);
        check("t5_reowner", 32'(owner), 0);
        clear_counts();
        watch(13);
        check("t5_explode_cnt", 32'(n_explode), 1);
        check("t5_flame_cnt", 32'(n_flame), 3);
        check("t5_idle", 32'(busy), 0);

        // External clear mid-fuse: straight to flame, no explode
        req_p1 = 1'b1;
        tick();
        req_p1 = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        check("t6_fuse2", 32'(fuse_left), 2);
        kill = 1'b1;
        tick();
        kill = 1'b0;
        check("t6_flame", 32'(flame_on), 1);
        check("t6_expl", 32'(explode), 0);
        check("t6_fuse0", 32'(fuse_left), 0);
        clear_counts();
        watch(5);
        check("t6_flame_cnt", 32'(n_flame), 2);
        check("t6_explode_cnt", 32'(n_explode), 0);
        check("t6_idle", 32'(busy), 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
